// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter and sequencer in front of the NOR-flash
// controller. A winning client's command/address/write data are latched in
// IDLE, a one-cycle run pulse is issued in LAUNCH, and the arbiter waits in
// WAIT for the controller's end-of-operation pulse (or a watchdog timeout).
// A one-cycle done (plus err on timeout) pulse goes back to the winner in DONE.
//
// Ports:
//   clk, reset              system clock, asynchronous active-low reset
//   reqN, comN, addrN,      client N request level, command (0 nocom, 1 read,
//   wdataN                  2 write, 3 erase), address, write data
//   doneN, errN             client N completion / timeout pulses
//   rdata                   last read data, valid with done0|done1
//   mem_run, mem_com,       start pulse and latched command/address/data
//   mem_addr, mem_wdata     toward the controller
//   mem_wdata_oe            write data bus enable (WAIT, write only)
//   mem_rdata, mem_endop    controller read data and end-of-operation pulse
//   busy                    high whenever the sequencer is not IDLE
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority over port 1.
module mem_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [1:0]  com0,
  input  logic [21:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic [1:0]  com1,
  input  logic [21:0] addr1,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        err0,
  output logic        done1,
  output logic        err1,
  output logic [15:0] rdata,
  output logic        mem_run,
  output logic [1:0]  mem_com,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [15:0] mem_rdata,
  input  logic        mem_endop,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] TO_C = 16'(TIMEOUT);

  state_t      state_r, state_n;
  logic        win_r, win_n;
  logic        flag_r, flag_n;
  logic [15:0] wd_r, wd_n;
  logic [1:0]  com_r, com_n;
  logic [21:0] addr_r, addr_n;
  logic [15:0] wdata_r, wdata_n;
  logic [15:0] rdata_r, rdata_n;
  logic        run_r, run_n;
  logic        oe_r, oe_n;
  logic        done0_r, done0_n;
  logic        done1_r, done1_n;
  logic        err0_r, err0_n;
  logic        err1_r, err1_n;
  logic        busy_r, busy_n;
  logic        pick_s;
  logic [15:0] wd_inc_s;
  logic        timeout_s;
`ifdef MEM_ARB_RR_EN
  logic        ptr_r, ptr_n;
`endif

  // Winner selection among currently requesting ports.
  always_comb begin
    pick_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    // Pointer only matters on a tie; a lone requester always wins.
    if (req0 && req1) begin
      pick_s = ptr_r;
    end else begin
      pick_s = ~req0;
    end
`else
    if (req0) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`endif
  end

  // Saturating watchdog increment; "reaches TIMEOUT" means the incremented
  // value equals TIMEOUT, so WAIT lasts exactly TIMEOUT cycles.
  always_comb begin
    if (wd_r < TO_C) begin
      wd_inc_s = wd_r + 16'd1;
    end else begin
      wd_inc_s = wd_r;
    end
    timeout_s = (wd_inc_s == TO_C);
  end

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_n = state_r;
    win_n   = win_r;
    flag_n  = flag_r;
    wd_n    = wd_r;
    com_n   = com_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    rdata_n = rdata_r;
`ifdef MEM_ARB_RR_EN
    ptr_n   = ptr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          win_n   = pick_s;
          com_n   = pick_s ? com1   : com0;
          addr_n  = pick_s ? addr1  : addr0;
          wdata_n = pick_s ? wdata1 : wdata0;
          if (com_n == 2'd0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_LAUNCH;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        wd_n    = 16'd0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // endop takes precedence over a simultaneous timeout.
        if (mem_endop) begin
          if (com_r == 2'd1) begin
            rdata_n = mem_rdata;
          end else begin
            rdata_n = rdata_r;
          end
          state_n = ST_DONE;
        end else if (timeout_s) begin
          flag_n  = 1'b1;
          state_n = ST_DONE;
        end else begin
          wd_n = wd_inc_s;
        end
      end
      ST_DONE: begin
        flag_n  = 1'b0;
`ifdef MEM_ARB_RR_EN
        ptr_n   = ~win_r;
`endif
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    run_n   = (state_n == ST_LAUNCH);
    oe_n    = (state_n == ST_WAIT) && (com_n == 2'd2);
    done0_n = (state_n == ST_DONE) && !win_n;
    done1_n = (state_n == ST_DONE) && win_n;
    err0_n  = done0_n && flag_n;
    err1_n  = done1_n && flag_n;
    busy_n  = (state_n != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      win_r   <= 1'b0;
      flag_r  <= 1'b0;
      wd_r    <= 16'd0;
      com_r   <= 2'd0;
      addr_r  <= 22'd0;
      wdata_r <= 16'd0;
      rdata_r <= 16'd0;
      run_r   <= 1'b0;
      oe_r    <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      win_r   <= win_n;
      flag_r  <= flag_n;
      wd_r    <= wd_n;
      com_r   <= com_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
      rdata_r <= rdata_n;
      run_r   <= run_n;
      oe_r    <= oe_n;
      done0_r <= done0_n;
      done1_r <= done1_n;
      err0_r  <= err0_n;
      err1_r  <= err1_n;
      busy_r  <= busy_n;
`ifdef MEM_ARB_RR_EN
      ptr_r   <= ptr_n;
`endif
    end
  end

  assign done0        = done0_r;
  assign err0         = err0_r;
  assign done1        = done1_r;
  assign err1         = err1_r;
  assign rdata        = rdata_r;
  assign mem_run      = run_r;
  assign mem_com      = com_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign mem_wdata_oe = oe_r;
  assign busy         = busy_r;

endmodule
